// File: rtl/gf180mcu_fd_sc_mcu9t5v0__evt_sync_1.sv
// Event capture behind the OR4 cell: synchronize E, detect rising edges, queue them, hand off via 4-phase REQ/ACK.
// Optional glitch filter on the synchronized level: GF180MCU_FD_SC_MCU9T5V0_EVT_GLITCH_FILTER_EN.
module gf180mcu_fd_sc_mcu9t5v0__evt_sync_1 #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 3,
  parameter int CNT_W       = 8,
  parameter int FILT_CYCLES = 3
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              E,
  input  logic              ACK,
  input  logic              CLR,
  output logic              REQ,
  output logic [CNT_W-1:0]  CNT,
  output logic              OVF,
  output logic [PEND_W-1:0] PEND,
  inout  wire               VDD,
  inout  wire               VSS
);

  typedef enum logic [1:0] {IDLE, REQ_HI, WAIT_ACK_LO} state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  function automatic logic [PEND_W-1:0] pend_sat_inc(input logic [PEND_W-1:0] v);
    return (v == PEND_MAX) ? v : v + PEND_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_wrap_inc(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_es;
  logic                   w_lvl;
  logic                   r_lvl_p1;
  logic                   r_ev_p2;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PEND_W-1:0]      r_pend;
  logic [PEND_W-1:0]      w_pend_nxt;
  logic                   w_drop;
  logic                   w_wrap;
  logic                   r_req;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_ovf;
  logic                   w_unused;

  // Supply pins carry no logic function.
  assign w_unused = &{1'b0, VDD, VSS, 1'(FILT_CYCLES)};

  // Stage p0: metastability synchronizer on the asynchronous event line
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], E};
  end

  assign w_es = r_sync[SYNC_STAGES-1];

`ifdef GF180MCU_FD_SC_MCU9T5V0_EVT_GLITCH_FILTER_EN
  localparam logic [3:0] FILT_MAX = 4'(FILT_CYCLES);
  logic [3:0] r_filt;

  // Level only qualifies after es has stayed high for FILT_CYCLES clocks.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN)                  r_filt <= '0;
    else if (!w_es)           r_filt <= '0;
    else if (r_filt != FILT_MAX) r_filt <= r_filt + 4'd1;
  end

  assign w_lvl = (r_filt == FILT_MAX);
`else
  assign w_lvl = w_es;
`endif

  // Stage p1/p2: edge register and registered rising-edge strobe
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_lvl_p1 <= 1'b0;
      r_ev_p2  <= 1'b0;
    end else begin
      r_lvl_p1 <= w_lvl;
      r_ev_p2  <= w_lvl & ~r_lvl_p1;
    end
  end

  // Handshake FSM; events arriving outside IDLE are queued in the pending counter.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_ev_p2) begin
          w_state_nxt = REQ_HI;
        end else if (r_pend != '0) begin
          w_state_nxt = REQ_HI;
          w_pend_nxt  = r_pend - PEND_W'(1);
        end
      end
      REQ_HI: begin
        if (ACK) w_state_nxt = WAIT_ACK_LO;
        if (r_ev_p2) begin
          w_pend_nxt = pend_sat_inc(r_pend);
          w_drop     = (r_pend == PEND_MAX);
        end
      end
      WAIT_ACK_LO: begin
        if (!ACK) w_state_nxt = IDLE;
        if (r_ev_p2) begin
          w_pend_nxt = pend_sat_inc(r_pend);
          w_drop     = (r_pend == PEND_MAX);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_req   <= (w_state_nxt == REQ_HI);
    end
  end

  assign w_wrap = r_ev_p2 & (r_cnt == CNT_MAX);

  // Event counter: counts every edge, even those dropped from the queue.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (CLR) begin
      r_cnt <= r_ev_p2 ? CNT_W'(1) : '0;
      r_ovf <= 1'b0;
    end else begin
      if (r_ev_p2)         r_cnt <= cnt_wrap_inc(r_cnt);
      if (w_wrap | w_drop) r_ovf <= 1'b1;
    end
  end

  assign REQ  = r_req;
  assign CNT  = r_cnt;
  assign OVF  = r_ovf;
  assign PEND = r_pend;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__evt_sync_1.sv
// Directed self-checking bench for the event synchronizer / handshake block.
module tb_gf180mcu_fd_sc_mcu9t5v0__evt_sync_1;

  localparam int FILT = 3;
`ifdef GF180MCU_FD_SC_MCU9T5V0_EVT_GLITCH_FILTER_EN
  localparam int LAT = 4 + FILT;
`else
  localparam int LAT = 4;
`endif

  logic       clk;
  logic       rn;
  logic       e;
  logic       man_ack;
  logic       auto_en;
  logic       auto_q;
  logic       clr;
  logic       req;
  logic [7:0] cnt;
  logic       ovf;
  logic [2:0] pend;
  logic       ack;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  assign ack = auto_en ? auto_q : man_ack;

  gf180mcu_fd_sc_mcu9t5v0__evt_sync_1 #(
    .SYNC_STAGES(2), .PEND_W(3), .CNT_W(8), .FILT_CYCLES(FILT)
  ) dut (
    .CLK(clk), .RN(rn), .E(e), .ACK(ack), .CLR(clr),
    .REQ(req), .CNT(cnt), .OVF(ovf), .PEND(pend),
    .VDD(vdd), .VSS(vss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer model: acknowledge follows REQ one half-cycle later.
  always @(negedge clk) auto_q <= req;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rn = 1'b0; e = 1'b0; man_ack = 1'b0; clr = 1'b0;
    @(negedge clk);
    rn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    e = 1'b1;
    repeat (hi) @(negedge clk);
    e = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic serve(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req) got = 1'b1;
    end
    if (got) begin
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int served;
    bit got;
    bit seen;
    rn = 1'b0; e = 1'b0; man_ack = 1'b0; clr = 1'b0; auto_en = 1'b0;

    // Reset with E toggling, then a single event.
    repeat (3) begin @(negedge clk); e = ~e; end
    chk("rst_req", 32'(req), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_pend", 32'(pend), 0);
    rn = 1'b1; e = 1'b0;
    repeat (3) @(negedge clk);
    e = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (req && lat == 0) lat = i;
    end
    e = 1'b0;
    chk("single_latency", 32'(lat), 32'(LAT));
    chk("single_cnt", 32'(cnt), 1);
    man_ack = 1'b1;
    @(negedge clk);
    chk("single_req_drop", 32'(req), 0);
    man_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("single_idle_req", 32'(req), 0);

    // Queued events served one handshake at a time.
    do_reset();
    repeat (4) pulse(4, 4);
    chk("queue_pend", 32'(pend), 3);
    chk("queue_cnt", 32'(cnt), 4);
    served = 0;
    for (int k = 0; k < 4; k++) begin
      serve(got);
      if (got) served++;
    end
    chk("queue_served", 32'(served), 4);
    chk("queue_pend_end", 32'(pend), 0);
    repeat (5) @(negedge clk);
    chk("queue_req_end", 32'(req), 0);
    chk("queue_cnt_end", 32'(cnt), 4);

    // Pending saturation while REQ is held.
    do_reset();
    repeat (8) pulse(4, 4);
    chk("sat8_pend", 32'(pend), 7);
    chk("sat8_ovf", 32'(ovf), 0);
    pulse(4, 4);
    chk("sat9_pend", 32'(pend), 7);
    chk("sat9_ovf", 32'(ovf), 1);
    chk("sat9_cnt", 32'(cnt), 9);
    chk("sat9_req", 32'(req), 1);

    // Counter wrap, then clear coincident with an event.
    do_reset();
    auto_en = 1'b1;
    repeat (255) pulse(4, 6);
    chk("wrap255_cnt", 32'(cnt), 255);
    chk("wrap255_ovf", 32'(ovf), 0);
    chk("wrap255_pend", 32'(pend), 0);
    pulse(4, 6);
    chk("wrap_cnt", 32'(cnt), 0);
    chk("wrap_ovf", 32'(ovf), 1);
    e = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_ev_cnt", 32'(cnt), 1);
    chk("clr_ev_ovf", 32'(ovf), 0);
    e = 1'b0;
    repeat (8) @(negedge clk);
    pulse(4, 6);
    chk("post_clr_cnt", 32'(cnt), 2);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_only_cnt", 32'(cnt), 0);
    repeat (4) @(negedge clk);
    auto_en = 1'b0;
    repeat (4) @(negedge clk);

    // Asynchronous reset while REQ is high.
    do_reset();
    repeat (3) pulse(4, 4);
    chk("mid_a_req", 32'(req), 1);
    chk("mid_a_pend", 32'(pend), 2);
    #2 rn = 1'b0;
    #1;
    chk("mid_a_req_async", 32'(req), 0);
    chk("mid_a_pend_async", 32'(pend), 0);
    @(negedge clk);
    rn = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset in WAIT_ACK_LO with two queued events.
    repeat (3) pulse(4, 4);
    man_ack = 1'b1;
    @(negedge clk);
    chk("mid_b_wait_req", 32'(req), 0);
    chk("mid_b_wait_pend", 32'(pend), 2);
    #2 rn = 1'b0;
    #1;
    chk("mid_b_req_async", 32'(req), 0);
    chk("mid_b_pend_async", 32'(pend), 0);
    chk("mid_b_cnt_async", 32'(cnt), 0);
    @(negedge clk);
    rn = 1'b1;
    man_ack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req) seen = 1'b1;
      man_ack = ~man_ack;
    end
    man_ack = 1'b0;
    chk("mid_b_no_req", 32'(seen), 0);
    chk("mid_b_pend_end", 32'(pend), 0);

`ifdef GF180MCU_FD_SC_MCU9T5V0_EVT_GLITCH_FILTER_EN
    // Glitch filter: short pulse rejected, long pulse delayed by FILT cycles.
    do_reset();
    seen = 1'b0;
    e = 1'b1;
    repeat (2) begin @(negedge clk); if (req) seen = 1'b1; end
    e = 1'b0;
    repeat (10) begin @(negedge clk); if (req) seen = 1'b1; end
    chk("filt_short_req", 32'(seen), 0);
    chk("filt_short_cnt", 32'(cnt), 0);
    e = 1'b1;
    lat = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (req && lat == 0) lat = i;
      if (i == 5) e = 1'b0;
    end
    chk("filt_long_latency", 32'(lat), 7);
    chk("filt_long_cnt", 32'(cnt), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__evt_sync_1.md
Name: gf180mcu_fd_sc_mcu9t5v0__evt_sync_1

Overview:
- Event-capture stage directly downstream of the 4-input OR cell. Its E input takes the OR-ed asynchronous event line (the OR4 Z output).
- Synchronizes E into the CLK domain, detects rising edges, queues pending events and presents them to a consumer over a four-phase REQ/ACK handshake.
- Keeps a wrapping event count with a sticky overflow flag for wake-up/interrupt aggregation in MCU designs.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on E; legal range 2..4.
- PEND_W, 3, width of the pending-event counter; saturates at 2^PEND_W-1.
- CNT_W, 8, width of the total event counter CNT.
- FILT_CYCLES, 3, stable-high cycles required by the glitch filter (optional feature only); legal range 1..15.

Ports:
- CLK  input  1  rising-edge clock
- RN  input  1  asynchronous active-low reset
- E  input  1  asynchronous event line (OR4 Z)
- ACK  input  1  consumer acknowledge, four-phase
- CLR  input  1  synchronous clear of CNT and OVF
- REQ  output  1  event request to consumer
- CNT  output  CNT_W  total accepted rising edges, wraps
- OVF  output  1  sticky: CNT wrapped, or an event arrived while pending was saturated
- PEND  output  PEND_W  queued events not yet requested
- VDD  inout  1  supply
- VSS  inout  1  ground

Behaviour:
- Reset: one clock, CLK. Reset is asynchronous and active-low on RN. While RN=0: all synchronizer flops, edge register, FSM=IDLE, REQ=0, CNT=0, OVF=0, PEND=0, applied immediately, no clock needed. Deassertion takes effect at the first CLK rise with RN=1.
- Synchronizer: E passes through SYNC_STAGES flops to give es. Edge register holds es from the previous cycle. A rising edge (ev) is es=1 and the previous value 0.
- Latency: E rise to ev is SYNC_STAGES+1 CLK rises. ev in IDLE drives REQ=1 on the next CLK rise.
- FSM states IDLE, REQ_HI, WAIT_ACK_LO:
  - IDLE: ev, or PEND>0 → REQ_HI, REQ=1. If the transition is caused by PEND>0 only (no ev), PEND decrements by 1.
  - REQ_HI: ACK=1 → WAIT_ACK_LO, REQ=0.
  - WAIT_ACK_LO: ACK=0 → IDLE.
- REQ is registered and changes only on state entry.
- Events while not idle:
  - ev in REQ_HI or WAIT_ACK_LO increments PEND.
  - If PEND is saturated, the event is dropped from PEND and OVF is set.
- Simultaneous ev and pending dequeue in IDLE: ev is served, PEND is unchanged.
- ACK=1 while in IDLE is ignored.
- CNT:
  - Increments by 1 on every ev, including dropped ones, modulo 2^CNT_W.
  - A wrap from all-ones to 0 sets OVF.
- CLR:
  - Sets CNT=0 and OVF=0 on the next rise.
  - If ev coincides with CLR, CNT=1 and OVF=0.
  - CLR does not affect FSM or PEND.
- RN asserted mid-handshake drops REQ at once. After release the FSM is IDLE with PEND=0, and pending events are lost.
- Timing arcs: CLK→REQ, CLK→CNT, CLK→OVF, CLK→PEND = (1.0,1.0). RN→all outputs = (1.0,1.0). E has no timing check (asynchronous). Setup/hold checks of 1.0 on ACK and CLR versus CLK rise.

Optional Feature:
- Macro: GF180MCU_FD_SC_MCU9T5V0_EVT_GLITCH_FILTER_EN.
- Defined:
  - A 4-bit counter follows es. It resets to 0 whenever es=0 and counts up while es=1, saturating at FILT_CYCLES.
  - The filtered level ef is 1 when the count equals FILT_CYCLES. ev is the rising edge of ef.
  - Latency grows by FILT_CYCLES cycles. An es pulse shorter than FILT_CYCLES cycles produces no ev.
- Not defined: ev is taken from es directly, and no filter logic is present.

Test Plan:
- Reset, single event: RN=0 for 3 cycles with E toggling → REQ=0, CNT=0, OVF=0, PEND=0. Then RN=1, E rises → REQ=1 exactly 4 CLK rises after E's first sampling edge (SYNC_STAGES=2). CNT=1.
- Queued events: one event pending in REQ_HI, then 3 more E pulses, each 4 cycles wide, before ACK → PEND=3. Then 4 ACK handshakes → 4 REQ pulses, PEND ends at 0, CNT=4.
- Saturation: PEND_W=3, 9 events during one held REQ → PEND=7, OVF=1, CNT=9.
- Wrap and clear: 256 events with CNT_W=8 → CNT=0, OVF=1. Then CLR asserted with ev in the same cycle → CNT=1, OVF=0.
- Reset mid-operation: RN pulsed low while in WAIT_ACK_LO with PEND=2 → REQ=0 immediately (before the next CLK). After release, ACK toggling produces no REQ and PEND=0.
- Glitch filter (macro defined, FILT_CYCLES=3): 2-cycle E pulse → no REQ, CNT=0. 5-cycle E pulse → REQ rises 3 cycles later than the unfiltered latency, CNT=1.
